// File: rtl/analog_io_pkg.sv
// Shared definitions for the analog I/O pad sequencer: register map,
// STATUS bit layout and sequencing FSM states.
package analog_io_pkg;

  localparam int unsigned WB_DW    = 32;
  localparam int unsigned WB_SW    = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned REG_SPAN = 12;

  // Register word indices (byte offset >> 2)
  localparam logic [1:0] REG_MODE   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_LOCK   = 2'd2;

  localparam int unsigned ST_BUSY_BIT    = 0;
  localparam int unsigned ST_LOCK_BIT    = 1;
  localparam int unsigned ST_APPLIED_LSB = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_BREAK = 2'd1,
    SEQ_WAIT  = 2'd2
  } seq_state_e;

  // Expand Wishbone byte selects into a 32-bit write mask
  function automatic logic [WB_DW-1:0] byte_mask(input logic [WB_SW-1:0] sel);
    logic [WB_DW-1:0] m;
    m = '0;
    for (int b = 0; b < int'(WB_SW); b++) begin
      if (sel[b]) m[b*8 +: 8] = 8'hff;
    end
    return m;
  endfunction

endpackage

// File: rtl/analog_io_wb_regs.sv
// Wishbone classic slave for the sequencer: address decode, single-cycle
// ack, MODE/LOCK storage and STATUS readback.
module analog_io_wb_regs
  import analog_io_pkg::*;
#(
  parameter int unsigned NCH       = 6,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  input  logic [3:0]     wbs_sel_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  input  logic           busy,
  input  logic [NCH-1:0] applied,
  output logic [NCH-1:0] mode
);

  logic [31:0]    off;
  logic           hit;
  logic [31:0]    wmask;
  logic [31:0]    status;
  logic [31:0]    rdata;
  logic           ack_d;
  logic [31:0]    dat_d;
  logic [NCH-1:0] mode_d;
  logic           lock_q;
  logic           lock_d;

  // Decode, readback mux and register updates
  always_comb begin
    off    = wbs_adr_i - BASE_ADDR;
    hit    = off < 32'(REG_SPAN);
    wmask  = byte_mask(wbs_sel_i);
    status = 32'(applied) << ST_APPLIED_LSB;
    status[ST_BUSY_BIT] = busy;
    status[ST_LOCK_BIT] = lock_q;
    case (off[3:2])
      REG_MODE:   rdata = 32'(mode);
      REG_STATUS: rdata = status;
      REG_LOCK:   rdata = 32'(lock_q);
      default:    rdata = '0;
    endcase

    ack_d  = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
    dat_d  = '0;
    mode_d = mode;
    lock_d = lock_q;
    if (ack_d) begin
      if (wbs_we_i) begin
        if (off[3:2] == REG_MODE && !lock_q)
          mode_d = NCH'((32'(mode) & ~wmask) | (wbs_dat_i & wmask));
        if (off[3:2] == REG_LOCK && wbs_sel_i[0] && wbs_dat_i[0])
          lock_d = 1'b1;
      end else begin
        dat_d = rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      mode      <= '0;
      lock_q    <= 1'b0;
    end else begin
      wbs_ack_o <= ack_d;
      wbs_dat_o <= dat_d;
      mode      <= mode_d;
      lock_q    <= lock_d;
    end
  end

endmodule

// File: rtl/analog_io_sequencer.sv
// Break-before-make pad mode sequencer: changing channels are parked in
// analog (driver off) for DEADTIME cycles before the new mode is applied.
module analog_io_sequencer
  import analog_io_pkg::*;
#(
  parameter int unsigned NCH       = 6,
  parameter int unsigned DEADTIME  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_n,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  input  logic [3:0]     wbs_sel_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  input  logic           la_force_analog,
  output logic [NCH-1:0] io_oeb,
  output logic           busy
);

  seq_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0] applied_q, applied_d;
  logic [NCH-1:0] latched_q, latched_d;
  logic [NCH-1:0] mode;
  logic [NCH-1:0] target;
  logic [NCH-1:0] oeb_d;
  logic           busy_d;

  analog_io_wb_regs #(
    .NCH       (NCH),
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .busy      (busy),
    .applied   (applied_q),
    .mode      (mode)
  );

  // Next state; force-analog overrides everything and aborts a running sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    applied_d = applied_q;
    latched_d = latched_q;
    target    = la_force_analog ? '0 : mode;

    case (state_q)
      SEQ_IDLE: begin
        if (target != applied_q) begin
          state_d   = SEQ_BREAK;
          latched_d = target;
        end
      end
      SEQ_BREAK: begin
        state_d = SEQ_WAIT;
        cnt_d   = '0;
      end
      SEQ_WAIT: begin
        if (cnt_q == CNT_W'(DEADTIME - 1)) begin
          state_d   = SEQ_IDLE;
          applied_d = latched_q;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    if (la_force_analog) begin
      state_d   = SEQ_IDLE;
      applied_d = '0;
      cnt_d     = '0;
    end

    // Outputs follow the next state so they line up with the state register
    if (state_d == SEQ_IDLE) oeb_d = ~applied_d;
    else                     oeb_d = ~applied_d | (applied_d ^ latched_d);
    busy_d = (state_d != SEQ_IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= SEQ_IDLE;
      cnt_q     <= '0;
      applied_q <= '0;
      latched_q <= '0;
      io_oeb    <= '1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      applied_q <= applied_d;
      latched_q <= latched_d;
      io_oeb    <= oeb_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_analog_io_sequencer.sv
// Directed self-checking bench for analog_io_sequencer (NCH=6, DEADTIME=4).
module tb_analog_io_sequencer;

  localparam logic [31:0] BASE   = 32'h3000_0100;
  localparam logic [31:0] MODE_A = BASE;
  localparam logic [31:0] STAT_A = BASE + 32'h4;
  localparam logic [31:0] LOCK_A = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        la_force_analog;
  logic [5:0]  io_oeb;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  analog_io_sequencer dut (
    .wb_clk_i        (clk),
    .wb_rst_n        (rst_n),
    .wbs_cyc_i       (wbs_cyc_i),
    .wbs_stb_i       (wbs_stb_i),
    .wbs_we_i        (wbs_we_i),
    .wbs_adr_i       (wbs_adr_i),
    .wbs_dat_i       (wbs_dat_i),
    .wbs_sel_i       (wbs_sel_i),
    .wbs_ack_o       (wbs_ack_o),
    .wbs_dat_o       (wbs_dat_o),
    .la_force_analog (la_force_analog),
    .io_oeb          (io_oeb),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the ack cycle (or after the cycle budget expires)
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic acked, output logic [31:0] rdata);
    acked = 1'b0;
    rdata = '0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdata = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic        a;
    logic [31:0] d;
    wb_xfer(1'b1, adr, dat, sel, a, d);
    check({tag, "_ack"}, 32'(a), 32'd1);
  endtask

  task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic        a;
    logic [31:0] d;
    wb_xfer(1'b0, adr, 32'h0, 4'hf, a, d);
    check({tag, "_ack"}, 32'(a), 32'd1);
    check(tag, d, exp);
  endtask

  initial begin
    logic        a;
    logic [31:0] d;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0; wbs_sel_i = 0;
    la_force_analog = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_oeb",  32'(io_oeb), 32'h3f);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ack",  32'(wbs_ack_o), 32'h0);
    check("rst_dat",  wbs_dat_o, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("idle_oeb",  32'(io_oeb), 32'h3f);
    check("idle_busy", 32'(busy), 32'h0);
    rd("idle_status", STAT_A, 32'h0);

    // Single sequence to 000101: break N+1..N+5, applied from N+6
    wr("w5", MODE_A, 32'h5, 4'hf);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("seq5_oeb_n%0d", k),  32'(io_oeb), (k <= 5) ? 32'h3f : 32'h3a);
      check($sformatf("seq5_busy_n%0d", k), 32'(busy),   (k <= 5) ? 32'h1 : 32'h0);
    end
    rd("mode5", MODE_A, 32'h5);
    rd("stat5", STAT_A, 32'h500);

    // Rewriting the applied value starts nothing
    wr("wsame", MODE_A, 32'h5, 4'hf);
    repeat (3) tick();
    check("same_busy", 32'(busy), 32'h0);
    check("same_oeb",  32'(io_oeb), 32'h3a);

    // Back-to-back: 000101, then 000110 written mid-WAIT
    wr("w0", MODE_A, 32'h0, 4'hf);
    repeat (8) tick();
    check("zero_oeb", 32'(io_oeb), 32'h3f);
    wr("w5b", MODE_A, 32'h5, 4'hf);          // cycle N
    repeat (3) tick();                        // N+3
    wr("w6", MODE_A, 32'h6, 4'hf);           // ack in N+4
    tick();                                   // N+5
    check("b2b_busy_n5", 32'(busy), 32'h1);
    check("b2b_oeb_n5",  32'(io_oeb), 32'h3f);
    tick();                                   // N+6
    check("b2b_busy_n6", 32'(busy), 32'h0);
    check("b2b_oeb_n6",  32'(io_oeb), 32'h3a);
    tick();                                   // N+7
    check("b2b_busy_n7", 32'(busy), 32'h1);
    check("b2b_oeb_n7",  32'(io_oeb), 32'h3b);
    repeat (4) tick();                        // N+11
    check("b2b_busy_n11", 32'(busy), 32'h1);
    tick();                                   // N+12
    check("b2b_busy_n12", 32'(busy), 32'h0);
    check("b2b_oeb_n12",  32'(io_oeb), 32'h39);

    // Force analog during WAIT from applied 111111
    wr("w3f", MODE_A, 32'h3f, 4'hf);
    repeat (7) tick();
    check("all_dig_oeb", 32'(io_oeb), 32'h00);
    wr("w7", MODE_A, 32'h7, 4'hf);
    repeat (3) tick();
    check("pre_force_busy", 32'(busy), 32'h1);
    la_force_analog = 1'b1;
    tick();
    check("force_oeb",  32'(io_oeb), 32'h3f);
    check("force_busy", 32'(busy), 32'h0);
    rd("force_status", STAT_A, 32'h0);
    rd("force_mode",   MODE_A, 32'h7);

    // Release starts a sequence toward 000111; reset it during WAIT
    la_force_analog = 1'b0;
    tick();
    check("rel_busy_brk", 32'(busy), 32'h1);
    repeat (2) tick();
    check("rel_busy_wait", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_oeb",  32'(io_oeb), 32'h3f);
    check("arst_busy", 32'(busy), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    rd("arst_mode", MODE_A, 32'h0);
    repeat (6) tick();
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_oeb",  32'(io_oeb), 32'h3f);

    // Byte selects and unused MODE bits
    wr("wsel_none", MODE_A, 32'h3, 4'b1110);
    rd("sel_none_mode", MODE_A, 32'h0);
    wr("wsel_b0", MODE_A, 32'hffff_ffc3, 4'b0001);
    rd("sel_b0_mode", MODE_A, 32'h3);
    repeat (7) tick();
    check("mode3_oeb", 32'(io_oeb), 32'h3c);

    // Lock freezes MODE but writes are still acknowledged
    wr("wlock", LOCK_A, 32'h1, 4'hf);
    rd("lock_status", STAT_A, 32'h302);
    wr("wlocked", MODE_A, 32'h3f, 4'hf);
    repeat (3) tick();
    check("locked_busy", 32'(busy), 32'h0);
    check("locked_oeb",  32'(io_oeb), 32'h3c);
    rd("locked_mode", MODE_A, 32'h3);

    // Unmapped addresses never ack and read zero
    wb_xfer(1'b0, BASE + 32'hc, 32'h0, 4'hf, a, d);
    check("unmap_c_ack", 32'(a), 32'h0);
    check("unmap_c_dat", d, 32'h0);
    wb_xfer(1'b0, BASE - 32'h4, 32'h0, 4'hf, a, d);
    check("unmap_lo_ack", 32'(a), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/analog_io_sequencer.md
ANALOG_IO_SEQUENCER -- requirements
Module: analog_io_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 6, number of pad channels controlled (legal 1..32).
REQ-002 SHALL have parameter DEADTIME, default 4, break-before-make quiet period in clock cycles (legal 1..255).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3000_0100, Wishbone base address (word aligned).
REQ-004 SHALL have port wb_clk_i  input  1  single clock for all logic.
REQ-005 SHALL have port wb_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave controls.
REQ-007 SHALL have ports wbs_adr_i  input  32, wbs_dat_i  input  32, wbs_sel_i  input  4  Wishbone address, write data, byte selects.
REQ-008 SHALL have ports wbs_ack_o  output  1, wbs_dat_o  output  32  Wishbone acknowledge, read data.
REQ-009 SHALL have port la_force_analog  input  1  logic-analyzer override; high forces every channel to analog mode.
REQ-010 SHALL have port io_oeb  output  NCH  pad output-enable-bar per channel; 1 = digital driver off (analog), 0 = digital driver on.
REQ-011 SHALL have port busy  output  1  high while a mode transition sequence is in progress.

Function
REQ-012 Registers (offset from BASE_ADDR): 0x0 MODE (rw, bits[NCH-1:0], 1 = digital), 0x4 STATUS (ro: bit0 busy, bit1 lock, bits[NCH+7:8] applied mode), 0x8 LOCK (write bit0=1 sets lock; cannot be cleared except by reset).
REQ-013 SHALL assert wbs_ack_o for exactly one cycle, one cycle after cyc&stb is first sampled high; no ack for addresses outside the three registers' word range, and wbs_dat_o SHALL be 0 for unmapped reads.
REQ-014 Writes SHALL honour wbs_sel_i per byte; unused MODE bits read 0.
REQ-015 MODE writes while lock=1 SHALL be acknowledged but SHALL not change MODE.
REQ-016 FSM states IDLE, BREAK, WAIT; IDLE->BREAK when target mode differs from applied mode; BREAK->WAIT next cycle; WAIT->IDLE after DEADTIME cycles counted in WAIT, applying target on exit.
REQ-017 Target mode SHALL equal MODE register, or all-zeros when la_force_analog=1.
REQ-018 In BREAK and WAIT, io_oeb SHALL be 1 on every channel whose bit differs between applied and latched target; unchanged channels keep their applied value.
REQ-019 Latency: write ack in cycle N -> changing channels io_oeb=1 from cycle N+1; new values on io_oeb from cycle N+2+DEADTIME.
REQ-020 Digital->analog changes SHALL reach io_oeb=1 at N+1 (break is final value); applied state still updates at sequence end.
REQ-021 Target SHALL be latched on IDLE->BREAK; target changes during BREAK/WAIT SHALL not alter the running sequence and SHALL start a fresh sequence from IDLE the cycle after completion if still different.
REQ-022 la_force_analog rising SHALL drive all io_oeb to 1 combinationally-registered in the next cycle, in any state, abort any sequence, and set applied mode to zeros.
REQ-023 busy SHALL be high exactly in BREAK and WAIT.
REQ-024 Write of MODE equal to applied mode SHALL not start a sequence.

Reset
REQ-025 On wb_rst_n low: io_oeb all 1, MODE 0, applied 0, lock 0, busy 0, wbs_ack_o 0, wbs_dat_o 0, FSM IDLE, counter 0.
REQ-026 Reset mid-sequence SHALL abort immediately; first post-reset sequence only after a new MODE write.

Structure
REQ-027 Register offsets, STATUS bit positions and FSM state enum SHALL live in shared package analog_io_pkg.
REQ-028 Wishbone decode/ack/readback SHALL be sub-module analog_io_wb_regs; sequencing FSM and counter in the top.

Verification
REQ-029 Reset release, no writes -> io_oeb=6'b111111, busy=0, STATUS read = 0.
REQ-030 Write MODE=6'b000101 at ack cycle N -> bits 0,2 io_oeb=1 cycles N+1..N+5, =0 from N+6; busy high N+1..N+5.
REQ-031 From applied 6'b000101 write 6'b000110 mid-WAIT of previous write -> current sequence completes, second sequence starts next cycle, final io_oeb=6'b111001.
REQ-032 Write LOCK=1 then MODE=6'b111111 -> ack returned, MODE reads old value, io_oeb unchanged.
REQ-033 Applied 6'b111111, la_force_analog=1 during WAIT -> io_oeb=6'b111111 next cycle, busy=0, STATUS applied=0.
REQ-034 wb_rst_n low during WAIT -> io_oeb=all 1 immediately, busy=0, MODE reads 0.
